// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared I2C definitions.
// Holds the receiver state encoding, the bit-count terminal value and a helper
// for decoding the address byte. The master side can import it as well.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_t;

  // Number of bits in one byte on the wire; the bit counter stops here.
  localparam logic [3:0] BIT_CNT_LAST = 4'd8;

  // True when the address byte names own_addr and requests a write (R/W = 0).
  function automatic logic addr_write_hit(input logic [7:0] addr_byte,
                                          input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge -- synchroniser plus edge detector for one bus line.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   i_din            raw, asynchronous bus line
//   o_level          synchronised line level
//   o_rise / o_fall  one-clk pulses on synchronised rising / falling edge
// All flops reset to 1 so an idle (pulled-up) bus produces no edges.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_dly  <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_dly;
  assign o_fall  = ~o_level & r_dly;

endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx -- write-only I2C slave receiver.
// Ports:
//   clk, reset   system clock (>= 8x SCL), asynchronous active-high reset
//   scl, sda     raw bus lines
//   sda_oe       1 = pull SDA low (ACK)
//   rx_data      last complete data byte, rx_valid pulses when it updates
//   addr_match   high from address ACK until STOP / repeated START
//   busy         high from START until STOP
//   stop_det     one-clk pulse on STOP
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy,
  output logic       stop_det
);

  localparam int LINE_SCL = 0;
  localparam int LINE_SDA = 1;

  logic [1:0] w_line_in, w_level, w_rise, w_fall;
  assign w_line_in = {sda, scl};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_din  (w_line_in[gi]),
        .o_level(w_level[gi]),
        .o_rise (w_rise[gi]),
        .o_fall (w_fall[gi])
      );
    end
  endgenerate

  // Our own ACK only changes SDA while SCL is low, so it never looks like START/STOP.
  logic w_start, w_stop, w_scl_rise, w_scl_fall, w_last_bit;
  logic [7:0] w_byte;
  assign w_start    = w_fall[LINE_SDA] & w_level[LINE_SCL];
  assign w_stop     = w_rise[LINE_SDA] & w_level[LINE_SCL];
  assign w_scl_rise = w_rise[LINE_SCL];
  assign w_scl_fall = w_fall[LINE_SCL];

  i2c_state_t r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [6:0] r_shift, w_shift_next;
  logic       r_ack_on, w_ack_on_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_rx_valid, w_rx_valid_next;
  logic       r_addr_match, w_addr_match_next;
  logic       r_busy, w_busy_next;
  logic       r_stop_det, w_stop_det_next;

  // Byte as it stands once the bit being sampled now is shifted in.
  assign w_byte     = {r_shift, w_level[LINE_SDA]};
  assign w_last_bit = (r_cnt + 4'd1) == BIT_CNT_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_shift      <= 7'd0;
      r_ack_on     <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_addr_match <= 1'b0;
      r_busy       <= 1'b0;
      r_stop_det   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_shift      <= w_shift_next;
      r_ack_on     <= w_ack_on_next;
      r_rx_data    <= w_rx_data_next;
      r_rx_valid   <= w_rx_valid_next;
      r_addr_match <= w_addr_match_next;
      r_busy       <= w_busy_next;
      r_stop_det   <= w_stop_det_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_shift_next      = r_shift;
    w_ack_on_next     = r_ack_on;
    w_rx_data_next    = r_rx_data;
    w_rx_valid_next   = 1'b0;
    w_addr_match_next = r_addr_match;
    w_busy_next       = r_busy;
    w_stop_det_next   = 1'b0;

    // Bus conditions override any SCL edge seen in the same cycle.
    if (w_stop) begin
      w_state_next      = ST_IDLE;
      w_cnt_next        = 4'd0;
      w_ack_on_next     = 1'b0;
      w_addr_match_next = 1'b0;
      w_busy_next       = 1'b0;
      w_stop_det_next   = 1'b1;
    end else if (w_start) begin
      w_state_next      = ST_ADDR;
      w_cnt_next        = 4'd0;
      w_ack_on_next     = 1'b0;
      w_addr_match_next = 1'b0;
      w_busy_next       = 1'b1;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_next = w_byte[6:0];
            w_cnt_next   = r_cnt + 4'd1;
            if (w_last_bit) begin
              if (addr_write_hit(w_byte, SLAVE_ADDR)) begin
                w_state_next      = ST_ADDR_ACK;
                w_addr_match_next = 1'b1;
              end else begin
                w_state_next = ST_IGNORE;
              end
            end
          end
        end
        ST_DATA: begin
          if (w_scl_rise) begin
            w_shift_next = w_byte[6:0];
            w_cnt_next   = r_cnt + 4'd1;
            if (w_last_bit) begin
              w_rx_data_next  = w_byte;
              w_rx_valid_next = 1'b1;
              w_state_next    = ST_DATA_ACK;
            end
          end
        end
        // First SCL fall after the 8th bit drives ACK, the next one releases it.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_ack_on_next = 1'b1;
            end else begin
              w_ack_on_next = 1'b0;
              w_state_next  = ST_DATA;
              w_cnt_next    = 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe     = r_ack_on;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign addr_match = r_addr_match;
  assign busy       = r_busy;
  assign stop_det   = r_stop_det;

endmodule
